bcd_time_display: RTL and testbench



---
 rtl/bcd_time_display.sv | 235 +++++++++++++++++++++++
 tb/tb_bcd_time_display.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_display.sv
// bcd_time_display
// Reader side of the BCD time-count link. Accepts packed HH:MM:SS BCD over a
// valid/ready handshake and scans it onto a 6-digit multiplexed 7-segment
// display. Capture is double-buffered: an accepted value waits in a pending
// buffer and is copied into the display register only at a frame boundary,
// so one scan frame never shows a mix of two time values.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined   -> a hours-tens digit of 0 leaves the idx5 slot fully dark
//   undefined -> hours-tens is always shown, including "0"
//
// Digit order (an[0] is the rightmost digit):
//   idx0 sec units, idx1 sec tens, idx2 min units,
//   idx3 min tens,  idx4 hour units, idx5 hour tens

module bcd_time_display #(
  parameter int unsigned SCAN_DIV       = 1000, // clk cycles per digit slot, 4..65535
  parameter int unsigned BLANK_CYCLES   = 4,    // dark cycles at slot start, < SCAN_DIV
  parameter int unsigned SEG_ACTIVE_LOW = 1     // 1: seg/dp/an active-low pins
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [7:0] bcd_hours,
  input  logic [7:0] bcd_minutes,
  input  logic [7:0] bcd_seconds,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start,
  output logic       bcd_err
);

  // Handshake: an update transfers on any rising clk edge where
  // upd_valid && upd_ready. upd_ready is a pure function of the registered
  // pending-buffer state, so there is no combinational path from upd_valid.
  // The producer may change or drop the data once the transfer has happened.

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK_LIM = 16'(BLANK_CYCLES);
  localparam logic [2:0]  IDX_LAST  = 3'd5;
  localparam logic        POL       = (SEG_ACTIVE_LOW != 0);

  // Pin levels for "everything off" in the selected polarity.
  localparam logic [5:0] AN_OFF  = {6{POL}};
  localparam logic [6:0] SEG_OFF = {7{POL}};
  localparam logic       DP_OFF  = POL;

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show "-".
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // True when any of the six nibbles is outside 0..9.
  function automatic logic has_bad_nibble(input logic [23:0] v);
    logic e;
    e = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (v[4*i +: 4] > 4'd9) e = 1'b1;
    end
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0] presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  logic        first_q;           // high for the first cycle after reset release
  logic [23:0] pend_q, pend_d;
  logic        pend_full_q, pend_full_d;
  logic [23:0] disp_q, disp_d;
  logic        err_q, err_d;

  logic [5:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        fs_q, fs_d;

  // ---------------------------------------------------------------------------
  // Scan timing and frame boundary
  // ---------------------------------------------------------------------------
  logic presc_wrap;
  logic frame_bound;

  // Prescaler counts through one slot; the digit index steps at each wrap.
  always_comb begin
    presc_wrap = (presc_q == PRESC_MAX);
    presc_d    = presc_wrap ? 16'd0 : presc_q + 16'd1;
    idx_d      = idx_q;
    if (presc_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    end
    // The last cycle of slot 5 closes a frame; the first cycle after reset
    // release also counts so that the scan starts from a clean boundary.
    frame_bound = first_q || (presc_wrap && (idx_q == IDX_LAST));
  end

  // ---------------------------------------------------------------------------
  // Capture and double-buffer transfer
  // ---------------------------------------------------------------------------
  logic accept;
  logic transfer;

  // Pending buffer fills on acceptance and drains into the display register
  // at a frame boundary. Both cannot happen in one cycle: acceptance needs
  // the buffer empty and transfer needs it full, so there is no bypass path.
  always_comb begin
    accept      = upd_valid && !pend_full_q;
    transfer    = frame_bound && pend_full_q;
    pend_d      = accept ? {bcd_hours, bcd_minutes, bcd_seconds} : pend_q;
    pend_full_d = pend_full_q;
    if (transfer) begin
      pend_full_d = 1'b0;
    end else if (accept) begin
      pend_full_d = 1'b1;
    end
    disp_d = transfer ? pend_q : disp_q;
    err_d  = transfer ? has_bad_nibble(pend_q) : err_q;
  end

  // ---------------------------------------------------------------------------
  // Pin pipeline: derived from the current prescaler/index/display state and
  // registered, so every pin lags the scan state by exactly one cycle.
  // ---------------------------------------------------------------------------
  logic [3:0] slot_nib;
  logic       in_blank;
  logic       lz_blank;
  logic       show;
  logic [5:0] an_act;
  logic [6:0] seg_act;
  logic       dp_act;

  // Pick the nibble belonging to the current digit slot.
  always_comb begin
    case (idx_q)
      3'd0:    slot_nib = disp_q[3:0];
      3'd1:    slot_nib = disp_q[7:4];
      3'd2:    slot_nib = disp_q[11:8];
      3'd3:    slot_nib = disp_q[15:12];
      3'd4:    slot_nib = disp_q[19:16];
      3'd5:    slot_nib = disp_q[23:20];
      default: slot_nib = 4'd0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign lz_blank = (idx_q == IDX_LAST) && (slot_nib == 4'd0);
`else
  assign lz_blank = 1'b0;
`endif

  // Build active-high pin values, then apply the board polarity.
  always_comb begin
    in_blank = (presc_q < BLANK_LIM);
    show     = !in_blank && !lz_blank;
    an_act   = show ? (6'b000001 << idx_q) : 6'b000000;
    seg_act  = show ? seg_decode(slot_nib) : 7'h00;
    dp_act   = show && ((idx_q == 3'd2) || (idx_q == 3'd4));
    an_d     = an_act ^ AN_OFF;
    seg_d    = seg_act ^ SEG_OFF;
    dp_d     = dp_act ^ DP_OFF;
    fs_d     = (presc_q == 16'd0) && (idx_q == 3'd0);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Scan counters and the post-reset boundary flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= 16'd0;
      idx_q   <= 3'd0;
      first_q <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      first_q <= 1'b0;
    end
  end

  // Pending buffer, display register and the frame error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= 24'h000000;
      pend_full_q <= 1'b0;
      disp_q      <= 24'h000000;
      err_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      disp_q      <= disp_d;
      err_q       <= err_d;
    end
  end

  // Registered display pins and the frame marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
      fs_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fs_q  <= fs_d;
    end
  end

  assign upd_ready   = !pend_full_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;
  assign bcd_err     = err_q;

endmodule

// File: tb/tb_bcd_time_display.sv
// Testbench for bcd_time_display: randomized updates against a frame-level
// reference model with an expected-frame queue and a decoupled pin monitor.

module tb_bcd_time_display;

  localparam int SD  = 8;        // cycles per slot
  localparam int BC  = 2;        // blank cycles per slot
  localparam int FR  = 6 * SD;   // cycles per frame
  localparam bit LOW = 1'b1;     // active-low pins

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       upd_valid = 1'b0;
  logic       upd_ready;
  logic [7:0] bcd_hours = 8'h00;
  logic [7:0] bcd_minutes = 8'h00;
  logic [7:0] bcd_seconds = 8'h00;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;
  logic       bcd_err;

  always #5 clk = ~clk;

  bcd_time_display #(
    .SCAN_DIV      (SD),
    .BLANK_CYCLES  (BC),
    .SEG_ACTIVE_LOW(LOW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .bcd_hours  (bcd_hours),
    .bcd_minutes(bcd_minutes),
    .bcd_seconds(bcd_seconds),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_start(frame_start),
    .bcd_err    (bcd_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  logic [23:0] exp_q[$];     // display value expected for each upcoming frame
  int          k_m = 0;      // clock edges since reset release
  logic [23:0] pend_m = '0;
  bit          pfull_m = 1'b0;
  logic [23:0] disp_m = '0;
  logic [6:0]  seg_tab [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, k_m, $time);
    end
  endtask

  function automatic bit any_bad(input logic [23:0] v);
    for (int i = 0; i < 6; i++) begin
      if (((v >> (4 * i)) & 24'hF) > 9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference model: frames are FR cycles long counted from reset release;
  // an accepted value moves to the display at the next frame-end edge that
  // comes strictly after its acceptance, and every frame's value is queued.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        k_m     = 0;
        pfull_m = 1'b0;
        pend_m  = '0;
        disp_m  = '0;
        exp_q.delete();
        exp_q.push_back(24'h000000);
      end else begin
        bit acc;
        acc = upd_valid && !pfull_m;
        k_m++;
        if (((k_m == 1) || (k_m % FR == 0)) && pfull_m) begin
          disp_m  = pend_m;
          pfull_m = 1'b0;
        end
        if (acc) begin
          pend_m  = {bcd_hours, bcd_minutes, bcd_seconds};
          pfull_m = 1'b1;
        end
        if (k_m % FR == 0) exp_q.push_back(disp_m);
      end
    end
  end

  // Monitor: samples on the falling edge, pops a frame value whenever the DUT
  // marks a frame start, and checks every pin against the expected frame.
  initial begin
    logic [23:0] cur;
    int          s, p, i;
    logic [3:0]  nib;
    bit          act;
    logic [5:0]  an_e;
    logic [6:0]  seg_e;
    logic        dp_e;
    cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur = '0;
        chk("rst_an", 32'(an), 32'h3F);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_ready", 32'(upd_ready), 32'h1);
        chk("rst_frame_start", 32'(frame_start), 32'h0);
        chk("rst_bcd_err", 32'(bcd_err), 32'h0);
      end else begin
        chk("frame_start", 32'(frame_start), 32'((k_m >= 1) && ((k_m - 1) % FR == 0)));
        chk("upd_ready", 32'(upd_ready), 32'(!pfull_m));
        if (frame_start) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame_queue: got frame_start with no expected frame (edge %0d)", k_m);
          end else begin
            cur = exp_q.pop_front();
          end
        end
        act = 1'b0;
        i   = 0;
        if (k_m >= 1) begin
          s   = k_m - 1;
          p   = s % SD;
          i   = (s / SD) % 6;
          nib = 4'((cur >> (4 * i)) & 24'hF);
          act = (p >= BC) && !(LZB && (i == 5) && (nib == 4'd0));
        end else begin
          nib = 4'd0;
        end
        an_e  = (act ? 6'(1 << i) : 6'h00) ^ {6{LOW}};
        seg_e = (act ? seg_tab[nib] : 7'h00) ^ {7{LOW}};
        dp_e  = (act && ((i == 2) || (i == 4))) ^ LOW;
        chk("an", 32'(an), 32'(an_e));
        chk("seg", 32'(seg), 32'(seg_e));
        chk("dp", 32'(dp), 32'(dp_e));
        if (k_m == 0) chk("bcd_err_idle", 32'(bcd_err), 32'h0);
        else if (k_m % FR != 0) chk("bcd_err", 32'(bcd_err), 32'(any_bad(cur)));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all called at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic waitc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one value and hold it until accepted, then scramble the bus.
  task automatic offer(input logic [23:0] d);
    int n;
    n = 0;
    upd_valid = 1'b1;
    {bcd_hours, bcd_minutes, bcd_seconds} = d;
    while (!upd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL offer_timeout: got upd_ready=0 for %0d cycles expected 1", n);
    end
    @(negedge clk);
    upd_valid = 1'b0;
    {bcd_hours, bcd_minutes, bcd_seconds} = 24'($urandom);
  endtask

  // Move to the falling edge after edge number k with k % FR == ph.
  task automatic align(input int ph);
    int n;
    n = 0;
    while ((k_m % FR != ph) && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic [23:0] rand_bcd();
    logic [23:0] v;
    v = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
         4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
         4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Idle frames showing 00:00:00.
    waitc(2 * FR);

    // One update mid-frame.
    waitc(20);
    offer(24'h123456);
    waitc(2 * FR);

    // Back-pressure: second value waits for the first to be displayed.
    offer(24'h111111);
    offer(24'h222222);
    waitc(3 * FR);

    // Acceptance on the frame-end edge, then one edge before it.
    align(FR - 1);
    offer(rand_bcd());
    waitc(2 * FR);
    align(FR - 2);
    offer(rand_bcd());
    waitc(2 * FR);

    // Invalid nibble, then a valid value clears the error.
    offer(24'h1A0000);
    waitc(2 * FR);
    offer(24'h100000);
    waitc(2 * FR);

    // Randomized traffic, some with arbitrary (possibly invalid) nibbles.
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) == 0) offer(24'($urandom));
      else offer(rand_bcd());
      waitc($urandom_range(0, 70));
    end
    waitc(2 * FR);

    // Asynchronous reset mid-slot while the pending buffer is full.
    align(10);
    offer(24'h987654);
    waitc(3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_an", 32'(an), 32'h3F);
    chk("async_rst_seg", 32'(seg), 32'h7F);
    chk("async_rst_dp", 32'(dp), 32'h1);
    chk("async_rst_ready", 32'(upd_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    waitc(2 * FR);

    // Hours-tens zero (dark slot when leading-zero blanking is built in).
    offer(24'h050000);
    waitc(2 * FR + 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
